// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the pipeline writeback stream and
// a multi-cycle unit. Writeback normally wins; after STALL_THRESH consecutive
// losses the mc request is forced through while the pipeline is frozen.
//
// Ports:
//   clk, clr_n                 clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data     pipeline writeback request
//   mc_req/mc_rd/mc_data       multi-cycle result request (held until mc_ack)
//   mc_ack                     mc request consumed this cycle (combinational)
//   pipe_stall                 writeback not consumed this cycle (combinational)
//   id_rs/id_rt                decode-stage source registers
//   mc_raw                     decode source hits a pending mc destination
//   rf_we/rf_rd/rf_wdata       registered register-file write port
module wb_port_arbiter #(
  parameter int unsigned STALL_THRESH = 3
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mc_req,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        mc_ack,
  output logic        pipe_stall,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        mc_raw,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             grant_wb;
  logic             grant_mc;
  logic             conflict;

  assign conflict = wb_valid & mc_req;
  assign cnt_inc  = wait_cnt + CNT_W'(1);

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    grant_wb = 1'b0;
    grant_mc = 1'b0;
    if (clr_n) begin
      if (state == STALL) begin
        grant_mc = mc_req;
      end else if (wb_valid) begin
        grant_wb = 1'b1;
      end else begin
        grant_mc = mc_req;
      end
    end
  end

  assign mc_ack     = grant_mc;
  assign pipe_stall = grant_mc & (state == STALL);
  assign mc_raw     = clr_n & mc_req & (mc_rd != REG_W'(0)) &
                      ((mc_rd == id_rs) | (mc_rd == id_rt));

  // Arbitration FSM and registered write port.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (conflict) begin
            wait_cnt <= CNT_W'(1);
            // A threshold of one forces the mc request on the very next cycle.
            state    <= (CNT_W'(1) >= THRESH) ? STALL : WAIT;
          end else begin
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (conflict) begin
            wait_cnt <= cnt_inc;
            if (cnt_inc >= THRESH) state <= STALL;
          end else begin
            state    <= IDLE;
            wait_cnt <= '0;
          end
        end
        STALL: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase

      // Writes to r0 are consumed but never reach the register file.
      rf_we <= 1'b0;
      if (grant_wb && wb_rd != REG_W'(0)) begin
        rf_we    <= 1'b1;
        rf_rd    <= wb_rd;
        rf_wdata <= DATA_W'(wb_data);
      end else if (grant_mc && mc_rd != REG_W'(0)) begin
        rf_we    <= 1'b1;
        rf_rd    <= mc_rd;
        rf_wdata <= DATA_W'(mc_data);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int unsigned THRESH = 3;

  logic        clk;
  logic        clr_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_req;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ack;
  logic        pipe_stall;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        mc_raw;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int n_checks;
  int n_errors;

  wb_port_arbiter #(.STALL_THRESH(THRESH)) dut (
    .clk(clk), .clr_n(clr_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_req(mc_req), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ack(mc_ack), .pipe_stall(pipe_stall),
    .id_rs(id_rs), .id_rt(id_rt), .mc_raw(mc_raw),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts consecutive cycles the mc request lost to
  // writeback; once the count hits the threshold the next cycle belongs to mc.
  int          m_losses;
  bit          m_force;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  function automatic bit exp_gwb();
    return clr_n && !m_force && wb_valid;
  endfunction

  function automatic bit exp_gmc();
    if (!clr_n) return 1'b0;
    if (m_force) return mc_req;
    return !wb_valid && mc_req;
  endfunction

  function automatic bit exp_raw();
    return clr_n && mc_req && (mc_rd != 5'd0) && (mc_rd == id_rs || mc_rd == id_rt);
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_losses <= 0;
      m_force  <= 1'b0;
      m_we     <= 1'b0;
      m_rd     <= '0;
      m_wdata  <= '0;
    end else begin
      m_we <= 1'b0;
      if (exp_gwb() && wb_rd != 5'd0) begin
        m_we <= 1'b1; m_rd <= wb_rd; m_wdata <= wb_data;
      end else if (exp_gmc() && mc_rd != 5'd0) begin
        m_we <= 1'b1; m_rd <= mc_rd; m_wdata <= mc_data;
      end
      if (m_force) begin
        m_force  <= 1'b0;
        m_losses <= 0;
      end else if (wb_valid && mc_req) begin
        m_losses <= m_losses + 1;
        if (m_losses + 1 >= int'(THRESH)) m_force <= 1'b1;
      end else begin
        m_losses <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] rs, input logic [4:0] rt);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    mc_req = mv; mc_rd = mr; mc_data = md;
    id_rs = rs; id_rt = rt;
  endtask

  typedef struct {
    logic        wv; logic [4:0] wr; logic [31:0] wd;
    logic        mv; logic [4:0] mr; logic [31:0] md;
    logic [4:0]  rs; logic [4:0] rt;
    logic        e_ack; logic e_stall; logic e_raw;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic wv, logic [4:0] wr, logic [31:0] wd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic [4:0] rs, logic [4:0] rt,
                              logic ea, logic es, logic er,
                              logic ew, logic [4:0] erd, logic [31:0] ewd);
    vec_t v;
    v.wv = wv; v.wr = wr; v.wd = wd; v.mv = mv; v.mr = mr; v.md = md;
    v.rs = rs; v.rt = rt; v.e_ack = ea; v.e_stall = es; v.e_raw = er;
    v.e_we = ew; v.e_rd = erd; v.e_wdata = ewd;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    //            wv wr  wd        mv mr  md        rs  rt   ack stl raw we rd  wdata
    vecs[0]  = mk(1, 5, 32'h1234, 0, 0, 32'h0,    0,  0,   0,  0,  0,  0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0,  0,  0,  1, 5, 32'h1234);
    vecs[2]  = mk(0, 0, 32'h0,    1, 9, 32'hCAFE, 0,  0,   1,  0,  0,  0, 5, 32'h1234);
    vecs[3]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0,  0,  0,  1, 9, 32'hCAFE);
    vecs[4]  = mk(1, 0, 32'hFFFF, 0, 0, 32'h0,    0,  0,   0,  0,  0,  0, 9, 32'hCAFE);
    vecs[5]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0,  0,  0,  0, 9, 32'hCAFE);
    vecs[6]  = mk(0, 0, 32'h0,    1, 7, 32'h77,   7,  0,   1,  0,  1,  0, 9, 32'hCAFE);
    vecs[7]  = mk(0, 0, 32'h0,    1, 7, 32'h77,   3,  3,   1,  0,  0,  1, 7, 32'h77);
    vecs[8]  = mk(0, 0, 32'h0,    1, 0, 32'h55,   0,  0,   1,  0,  0,  1, 7, 32'h77);
    vecs[9]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0,  0,  0,  0, 7, 32'h77);
    vecs[10] = mk(1, 1, 32'hA0,   1, 2, 32'hB0,   0,  0,   0,  0,  0,  0, 7, 32'h77);
    vecs[11] = mk(1, 1, 32'hA1,   1, 2, 32'hB0,   0,  0,   0,  0,  0,  1, 1, 32'hA0);
    vecs[12] = mk(1, 1, 32'hA2,   1, 2, 32'hB0,   0,  0,   0,  0,  0,  1, 1, 32'hA1);
    vecs[13] = mk(1, 1, 32'hA3,   1, 2, 32'hB0,   0,  0,   1,  1,  0,  1, 1, 32'hA2);
    vecs[14] = mk(1, 1, 32'hA3,   0, 2, 32'hB0,   0,  0,   0,  0,  0,  1, 2, 32'hB0);
    vecs[15] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0,  0,   0,  0,  0,  1, 1, 32'hA3);

    // Reset with an mc request pending: all combinational outputs gated.
    clr_n = 1'b0;
    drive(1, 4, 32'h1, 1, 4, 32'h2, 4, 4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mc_ack", 32'(mc_ack), 32'd0);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check("rst_mc_raw", 32'(mc_raw), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_rd", 32'(rf_rd), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);

    // Directed table: one row per cycle, inputs after posedge, checks at negedge.
    @(posedge clk); #1;
    clr_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wv, vecs[i].wr, vecs[i].wd, vecs[i].mv, vecs[i].mr, vecs[i].md,
            vecs[i].rs, vecs[i].rt);
      @(negedge clk);
      check($sformatf("vec%0d_mc_ack", i), 32'(mc_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_pipe_stall", i), 32'(pipe_stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_mc_raw", i), 32'(mc_raw), 32'(vecs[i].e_raw));
      check($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d_rf_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      @(posedge clk); #1;
    end

    // Reset pulse inside a STALL cycle abandons the forced mc grant.
    for (int i = 0; i < int'(THRESH); i++) begin
      drive(1, 3, 32'hD0 + 32'(i), 1, 6, 32'hE6, 0, 0);
      @(negedge clk);
      check("pre_stall_wb_wins", 32'(mc_ack), 32'd0);
      @(posedge clk); #1;
    end
    drive(1, 3, 32'hD9, 1, 6, 32'hE6, 0, 0);
    @(negedge clk);
    check("stall_mc_ack", 32'(mc_ack), 32'd1);
    check("stall_pipe_stall", 32'(pipe_stall), 32'd1);
    #1 clr_n = 1'b0;
    #1;
    check("stall_rst_mc_ack", 32'(mc_ack), 32'd0);
    check("stall_rst_pipe_stall", 32'(pipe_stall), 32'd0);
    check("stall_rst_rf_we", 32'(rf_we), 32'd0);
    check("stall_rst_rf_rd", 32'(rf_rd), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    check("post_rst_wb_first", 32'(mc_ack), 32'd0);
    check("post_rst_no_stall", 32'(pipe_stall), 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 1, 6, 32'hE6, 0, 0);
    @(negedge clk);
    check("post_rst_mc_regrant", 32'(mc_ack), 32'd1);
    check("post_rst_rf_rd_wb", 32'(rf_rd), 32'd3);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    check("post_rst_rf_we_mc", 32'(rf_we), 32'd1);
    check("post_rst_rf_rd_mc", 32'(rf_rd), 32'd6);
    check("post_rst_rf_wdata_mc", rf_wdata, 32'hE6);
    @(posedge clk); #1;

    // Random traffic against the reference model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      clr_n = ($urandom_range(0, 79) != 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      check("rnd_mc_ack", 32'(mc_ack), 32'(exp_gmc()));
      check("rnd_pipe_stall", 32'(pipe_stall), 32'(clr_n && m_force && mc_req));
      check("rnd_mc_raw", 32'(mc_raw), 32'(exp_raw()));
      check("rnd_rf_we", 32'(rf_we), 32'(m_we));
      check("rnd_rf_rd", 32'(rf_rd), 32'(m_rd));
      check("rnd_rf_wdata", rf_wdata, m_wdata);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STALL_THRESH, default 3: consecutive cycles an mc request may lose to writeback before forced stall; legal range 1-7.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports wb_valid in 1, wb_rd in 5, wb_data in 32: pipeline writeback request.
REQ-005 SHALL have ports mc_req in 1, mc_rd in 5, mc_data in 32: multi-cycle unit result request; held stable until acked.
REQ-006 SHALL have port mc_ack  out  1  mc request consumed this cycle.
REQ-007 SHALL have port pipe_stall  out  1  writeback not consumed this cycle; pipeline freezes and holds wb_* stable.
REQ-008 SHALL have ports id_rs in 5, id_rt in 5: decode-stage source registers.
REQ-009 SHALL have port mc_raw  out  1  decode source matches a pending, unacked mc destination.
REQ-010 SHALL have ports rf_we out 1, rf_rd out 5, rf_wdata out 32: register-file write port.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, STALL, plus 3-bit wait_cnt.
REQ-012 Grant in IDLE/WAIT: wb_valid=1 -> grant wb; else mc_req=1 -> grant mc; else no grant.
REQ-013 Grant in STALL: mc_req=1 -> grant mc and pipe_stall=1, regardless of wb_valid; mc_req=0 -> no grant, pipe_stall=0.
REQ-014 mc_ack and pipe_stall SHALL be combinational in the grant cycle; no other cycle asserts either.
REQ-015 rf_we/rf_rd/rf_wdata SHALL be registered: the granted request appears on the cycle after grant; rf_we=0 in cycles after no grant.
REQ-016 A granted request with rd=0 SHALL be consumed (mc_ack or wb taken) but SHALL produce rf_we=0; rf_rd/rf_wdata then hold their previous values.
REQ-017 Transitions: IDLE->WAIT when wb_valid and mc_req both 1, wait_cnt<=1.
REQ-018 In WAIT with wb_valid=1 and mc_req=1: wait_cnt increments; when incremented value reaches STALL_THRESH -> STALL.
REQ-019 WAIT -> IDLE, wait_cnt<=0, when mc granted (wb_valid=0) or mc_req drops.
REQ-020 STALL -> IDLE, wait_cnt<=0, unconditionally after one cycle.
REQ-021 IDLE stays IDLE with wait_cnt=0 whenever no wb/mc conflict occurs.
REQ-022 mc_raw SHALL equal mc_req & (mc_rd!=0) & (mc_rd==id_rs | mc_rd==id_rt); combinational, also asserted in the mc grant cycle.
REQ-023 The arbiter SHALL never emit two writes in one cycle nor drop a granted request.

Reset
REQ-024 clr_n=0 SHALL immediately force state IDLE, wait_cnt=0, rf_we=0, rf_rd=0, rf_wdata=0.
REQ-025 While clr_n=0, mc_ack=0, pipe_stall=0, mc_raw=0.
REQ-026 Reset mid-STALL SHALL abandon the grant; the mc request is not acked and is re-arbitrated from IDLE after release.
REQ-027 First grant possible in first posedge with clr_n=1.

Verification
REQ-028 wb_valid=1 rd=5 data=0x1234 alone -> next cycle rf_we=1 rf_rd=5 rf_wdata=0x1234; mc_ack=0, pipe_stall=0.
REQ-029 mc_req=1 rd=9 data=0xCAFE, wb_valid=0 -> mc_ack=1 same cycle; next cycle rf_we=1 rf_rd=9 rf_wdata=0xCAFE.
REQ-030 STALL_THRESH=3, wb_valid and mc_req held high -> wb granted cycles 0-2, cycle 3 mc_ack=1 pipe_stall=1, cycle 4 wb granted again, state IDLE.
REQ-031 wb_valid=1 rd=0 data=0xFFFF -> wb consumed, rf_we stays 0, rf_rd/rf_wdata unchanged.
REQ-032 mc_req=1 mc_rd=7, id_rs=7 -> mc_raw=1; id_rs=id_rt=3 -> mc_raw=0; mc_rd=0 with id_rs=0 -> mc_raw=0.
REQ-033 clr_n pulsed low during STALL cycle -> mc_ack=0, pipe_stall=0, rf_we=0 immediately; after release mc re-granted once wb_valid=0.
